sha256_msg_sequencer: RTL
=========================

# sha256_msg_sequencer

Streaming front-end for the SHA-256 compression core. It accepts a byte-aligned message as 32-bit big-endian words and applies SHA-256 padding and the 64-bit length field. It issues each 512-bit block to the core with a start/done handshake, carries the chaining value between blocks, and presents the final 256-bit digest. One message is processed at a time; the core is the only resource sequenced.

## Interface
- No parameters. IV, padding and length format are fixed by FIPS 180-4.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- s_valid  in  1  input word valid
- s_ready  out  1  sequencer accepts word this cycle
- s_data  in  32  message word; byte 0 in [31:24]
- s_last  in  1  final word of message
- s_bytes  in  3  valid bytes in final word, 0..4; ignored unless s_last; 5..7 treated as 4
- core_ready  in  1  core idle, may accept start
- core_start  out  1  one-cycle start pulse
- core_block  out  512  block; word 0 in [511:480]
- core_h_in  out  256  chaining value for this block, H0 in [255:224]
- core_done  in  1  one-cycle pulse, core_h_out valid
- core_h_out  in  256  updated chaining value (input H + compressed a..h)
- digest_valid  out  1  one-cycle pulse, digest final
- digest  out  256  last completed digest, held until next digest_valid
- busy  out  1  high in any state except FILL with idx=0 and byte_cnt=0

## Operation
- State: block buffer 16x32, idx[3:0], byte_cnt[60:0], H[255:0], pad_pending, final_blk.
- States: FILL, PAD, ISSUE, WAIT, DONE.
- FILL: s_ready=1. On s_valid&s_ready, write buf[idx], then idx+1.
  - Non-last word: byte_cnt += 4.
  - Last word with k=s_bytes: byte_cnt += k.
    - k<4: store data bytes 0..k-1, byte k = 0x80, remaining bytes 0. k=0 stores 0x80000000.
    - k=4: store the word unchanged and set pad_pending.
    - Then go to PAD.
  - Written word at idx 15, not last: go to ISSUE with final_blk=0, then return to FILL.
  - Last word written at idx 15: go to ISSUE with final_blk=0, then continue in PAD at idx 0.
- PAD: one word per cycle at idx.
  - pad_pending: write 0x80000000 and clear pad_pending.
  - Else idx 14: write bit_len[63:32].
  - Else idx 15 following a length write: write bit_len[31:0], final_blk=1, go to ISSUE.
  - Else: write 0.
  - Block filled without a length word: ISSUE with final_blk=0, then resume PAD at idx 0.
- bit_len = {byte_cnt, 3'b000}, modulo 2^64.
- ISSUE: when core_ready, pulse core_start with core_block=buf and core_h_in=H. Go to WAIT.
- WAIT: on core_done, H <= core_h_out and idx <= 0.
  - final_blk: go to DONE.
  - Else: return to FILL or PAD as recorded.
- DONE: digest <= H, digest_valid=1 for one cycle. H <= IV, byte_cnt <= 0, idx <= 0, go to FILL.
- IV = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- s_ready=0 in PAD, ISSUE, WAIT, DONE. Input words are never dropped or duplicated.

## Timing
- Reset values:
  - s_ready=0 during the reset cycle, 1 in the first cycle after.
  - core_start=0, core_block=0, core_h_in=0, digest_valid=0, digest=0, busy=0.
  - H=IV, state FILL.
- core_block and core_h_in are registered and stable from the core_start cycle through core_done.
- ISSUE waiting on core_ready: core_start stays low, nothing else changes.
- core_done outside WAIT is ignored.
- Padding takes one cycle per word written.
- Latency, last core_done to digest_valid: exactly 1 cycle.
- Next message accepted the cycle after digest_valid.
- Reset mid-message or mid-WAIT: state, H and counters return to reset values. A later stray core_done is ignored.

## Test plan
- "abc": one word 0x61626300 with s_last, s_bytes=3.
  - Exactly one core_start; block word0 = 61626380, words 1..14 = 0, word15 = 00000018.
  - With a reference core, digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: s_last with s_bytes=0.
  - word0 = 80000000, word15 = 0.
  - digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- 56-byte message (14 words, last s_bytes=4):
  - Two blocks. Block 1 word14 = 80000000, word15 = 0.
  - Block 2 words 0..13 = 0, word14 = 0, word15 = 000001c0. Block 2 core_h_in equals block 1 core_h_out.
- 64-byte message (16 words): two blocks; block 2 word0 = 80000000, word15 = 00000200.
- Flow control:
  - core_ready held low 10 cycles in ISSUE: no core_start, s_ready=0.
  - Random s_valid gaps give the same digest as a gap-free run.
  - digest_valid pulses exactly once per message.
- Reset asserted in WAIT of a two-block message, then "abc" sent:
  - The "abc" block uses core_h_in = IV.
  - The correct "abc" digest is produced; the stale core_done is ignored.

Source files
------------

// File: rtl/sha256_msg_sequencer.sv
// SHA-256 message front-end: packs big-endian words into 512-bit blocks, applies
// FIPS 180-4 padding and length, and sequences the compression core block by block.
module sha256_msg_sequencer (
   input  logic         clk,
   input  logic         reset,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   input  logic         s_last,
   input  logic [2:0]   s_bytes,
   input  logic         core_ready,
   output logic         core_start,
   output logic [511:0] core_block,
   output logic [255:0] core_h_in,
   input  logic         core_done,
   input  logic [255:0] core_h_out,
   output logic         digest_valid,
   output logic [255:0] digest,
   output logic         busy
);

   localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   typedef enum logic [2:0] {FILL, PAD, ISSUE, WAIT, DONE} state_t;

   state_t       state;
   logic [31:0]  blk_buf [16];
   logic [3:0]   idx;
   logic [60:0]  byte_cnt;
   logic [255:0] h;
   logic         pad_pending;
   logic         final_blk;
   logic         len_hi_done;
   logic         resume_pad;

   logic [2:0]   k;
   logic [31:0]  last_word;
   logic [63:0]  bit_len;
   logic [511:0] buf_flat;

   always_comb begin
      k = (s_bytes > 3'd4) ? 3'd4 : s_bytes;
      case (k)
         3'd0:    last_word = 32'h8000_0000;
         3'd1:    last_word = {s_data[31:24], 24'h80_0000};
         3'd2:    last_word = {s_data[31:16], 16'h8000};
         3'd3:    last_word = {s_data[31:8], 8'h80};
         default: last_word = s_data;
      endcase
      bit_len  = {byte_cnt, 3'b000};
      buf_flat = '0;
      for (int unsigned i = 0; i < 16; i++)
         buf_flat[511 - 32*i -: 32] = blk_buf[i];
      busy = !(state == FILL && idx == 4'd0 && byte_cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= FILL;
         idx          <= '0;
         byte_cnt     <= '0;
         h            <= IV;
         pad_pending  <= 1'b0;
         final_blk    <= 1'b0;
         len_hi_done  <= 1'b0;
         resume_pad   <= 1'b0;
         s_ready      <= 1'b0;
         core_start   <= 1'b0;
         core_block   <= '0;
         core_h_in    <= '0;
         digest_valid <= 1'b0;
         digest       <= '0;
         for (int unsigned i = 0; i < 16; i++)
            blk_buf[i] <= '0;
      end else begin
         core_start   <= 1'b0;
         digest_valid <= 1'b0;
         case (state)
            FILL: begin
               s_ready <= 1'b1;
               if (s_valid && s_ready) begin
                  idx <= idx + 4'd1;
                  if (s_last) begin
                     blk_buf[idx] <= last_word;
                     byte_cnt     <= byte_cnt + 61'(k);
                     pad_pending  <= (k == 3'd4);
                     len_hi_done  <= 1'b0;
                     s_ready      <= 1'b0;
                     if (idx == 4'd15) begin
                        state      <= ISSUE;
                        final_blk  <= 1'b0;
                        resume_pad <= 1'b1;
                     end else begin
                        state <= PAD;
                     end
                  end else begin
                     blk_buf[idx] <= s_data;
                     byte_cnt     <= byte_cnt + 61'd4;
                     if (idx == 4'd15) begin
                        state      <= ISSUE;
                        final_blk  <= 1'b0;
                        resume_pad <= 1'b0;
                        s_ready    <= 1'b0;
                     end
                  end
               end
            end
            PAD: begin
               idx <= idx + 4'd1;
               if (pad_pending) begin
                  blk_buf[idx] <= 32'h8000_0000;
                  pad_pending  <= 1'b0;
                  len_hi_done  <= 1'b0;
               end else if (idx == 4'd14) begin
                  blk_buf[idx] <= bit_len[63:32];
                  len_hi_done  <= 1'b1;
               end else if (idx == 4'd15 && len_hi_done) begin
                  blk_buf[idx] <= bit_len[31:0];
               end else begin
                  blk_buf[idx] <= '0;
                  len_hi_done  <= 1'b0;
               end
               // Block is final only when idx 15 completes a length pair.
               if (idx == 4'd15) begin
                  state      <= ISSUE;
                  resume_pad <= 1'b1;
                  final_blk  <= !pad_pending && len_hi_done;
               end
            end
            ISSUE: begin
               if (core_ready) begin
                  core_start <= 1'b1;
                  core_block <= buf_flat;
                  core_h_in  <= h;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (core_done) begin
                  h   <= core_h_out;
                  idx <= '0;
                  if (final_blk) begin
                     // Digest latched here so the pulse lands one cycle after core_done.
                     digest       <= core_h_out;
                     digest_valid <= 1'b1;
                     state        <= DONE;
                  end else if (resume_pad) begin
                     state <= PAD;
                  end else begin
                     state   <= FILL;
                     s_ready <= 1'b1;
                  end
               end
            end
            DONE: begin
               h           <= IV;
               byte_cnt    <= '0;
               idx         <= '0;
               final_blk   <= 1'b0;
               pad_pending <= 1'b0;
               len_hi_done <= 1'b0;
               state       <= FILL;
               s_ready     <= 1'b1;
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule
